ahb_mem_arbiter: RTL

Two-master AHB-Lite arbiter that shares the single-ported on-chip AHB-Lite memory slave between the Cortex-M0 (master 0) and a secondary master (master 1: DMA or debug/code loader). It sits between the two master buses and the memory's slave port. Each master gets a per-master address-phase holding stage so that a losing master is stalled with wait states, never dropped. Arbitration is round-robin or fixed-priority, set by parameter. An uncontested transfer adds zero cycles of latency.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_arb_in_stage.sv | 47 ++++
 rtl/ahb_mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared types for the two-master AHB-Lite memory arbiter.
// HTRANS encodings, data-phase owner and the address/control bundle.
package ahb_pkg;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
  } addr_ctrl_t;

endpackage

// File: rtl/ahb_arb_in_stage.sv
// Per-master address-phase hold stage: keeps a losing request
// until it is granted and presents held-or-live control.
module ahb_arb_in_stage
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  addr_ctrl_t live_i,
  input  logic       hready_i,
  input  logic       gnt_i,
  output logic       req_o,
  output logic       pend_o,
  output addr_ctrl_t sel_o
);

  addr_ctrl_t hold_q, hold_d;
  logic       pend_q, pend_d;
  logic       live;

  assign live   = live_i.htrans[1] & hready_i;
  assign req_o  = pend_q | live;
  assign pend_o = pend_q;
  assign sel_o  = pend_q ? hold_q : live_i;

  // live and pend never coexist: hready_i is low while pending
  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    if (gnt_i) begin
      pend_d = 1'b0;
    end else if (live) begin
      pend_d = 1'b1;
      hold_d = live_i;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single-ported memory.
// Uncontested transfers pass straight through; losers are held.
module ahb_mem_arbiter
  import ahb_pkg::*;
#(
  parameter int RR_MODE = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HRESP,
  output logic        S_HSEL,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA
);

  addr_ctrl_t ac0_live, ac1_live;
  addr_ctrl_t ac0_sel, ac1_sel, s_ac;
  logic       req0, req1, pend0, pend1;
  logic       gnt0, gnt1, adv;
  owner_e     dph_q, dph_d;
  owner_e     last_q, last_d;

  assign adv = S_HREADYOUT;

  assign ac0_live = '{haddr: M0_HADDR, htrans: M0_HTRANS,
                      hwrite: M0_HWRITE, hsize: M0_HSIZE};
  assign ac1_live = '{haddr: M1_HADDR, htrans: M1_HTRANS,
                      hwrite: M1_HWRITE, hsize: M1_HSIZE};

  ahb_arb_in_stage u_in0 (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .live_i   (ac0_live),
    .hready_i (M0_HREADY),
    .gnt_i    (gnt0),
    .req_o    (req0),
    .pend_o   (pend0),
    .sel_o    (ac0_sel)
  );

  ahb_arb_in_stage u_in1 (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .live_i   (ac1_live),
    .hready_i (M1_HREADY),
    .gnt_i    (gnt1),
    .req_o    (req1),
    .pend_o   (pend1),
    .sel_o    (ac1_sel)
  );

  // Master 0 wins a tie in fixed mode or when master 1 went last
  assign gnt0 = adv & req0 &
                (~req1 | (RR_MODE == 0) | (last_q == OWN_M1));
  assign gnt1 = adv & req1 & ~gnt0;

  always_comb begin
    s_ac = '0;
    unique case (1'b1)
      gnt0:    s_ac = ac0_sel;
      gnt1:    s_ac = ac1_sel;
      default: ;
    endcase
  end

  assign S_HSEL   = gnt0 | gnt1;
  assign S_HADDR  = s_ac.haddr;
  assign S_HTRANS = s_ac.htrans;
  assign S_HWRITE = s_ac.hwrite;
  assign S_HSIZE  = s_ac.hsize;
  assign S_HREADY = S_HREADYOUT;

  always_comb begin
    dph_d  = dph_q;
    last_d = last_q;
    unique case (1'b1)
      gnt0: begin
        dph_d  = OWN_M0;
        last_d = OWN_M0;
      end
      gnt1: begin
        dph_d  = OWN_M1;
        last_d = OWN_M1;
      end
      default: if (adv) dph_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_q  <= OWN_NONE;
      last_q <= OWN_M1;
    end else begin
      dph_q  <= dph_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    S_HWDATA = '0;
    unique case (dph_q)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: ;
    endcase
  end

  assign M0_HREADY = (dph_q == OWN_M0) ? S_HREADYOUT : ~pend0;
  assign M1_HREADY = (dph_q == OWN_M1) ? S_HREADYOUT : ~pend1;

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HRESP  = 1'b0;
  assign M1_HRESP  = 1'b0;

endmodule
